// File: rtl/camera_roi_packer.sv
// Crops an ROI from the pixel stream, packs 4x8-bit pixels per word into a show-ahead FIFO; word visible 2 cycles after the 4th pixel.
// Backpressure via M_READY; a push into a full FIFO drops the rest of the frame instead of stalling upstream.
module camera_roi_packer #(
    parameter int H     = 752,
    parameter int V     = 480,
    parameter int X0    = 0,
    parameter int Y0    = 0,
    parameter int W     = 752,
    parameter int HT    = 480,
    parameter int DEPTH = 16
) (
    input  logic                 PIXCLK,
    input  logic                 RST_N,
    input  logic                 FRAME_VALID,
    input  logic                 PIXEL_VALID,
    input  logic [9:0]           DATA_IN,
    input  logic [$clog2(V)-1:0] CURRENT_LINE,
    output logic [31:0]          M_DATA,
    output logic                 M_SOF,
    output logic                 M_EOL,
    output logic                 M_VALID,
    input  logic                 M_READY,
    output logic                 FRAME_DONE,
    output logic                 OVERFLOW,
    output logic [7:0]           DROPPED_FRAMES
);

    localparam int CW = $clog2(H);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DROP} state_t;

    state_t          state, state_nxt;
    logic            done_nxt;
    logic [CW-1:0]   col;
    logic [1:0]      lane;
    logic [23:0]     acc;
    logic            sof_pend;
    logic            push_vld, push_sof, push_eol;
    logic [31:0]     push_dat;

    logic [33:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    int              col_i, line_i;
    logic            in_roi, capture, empty, full, pop, ovf_evt, push_ok;

    always_comb begin
        col_i   = int'(col);
        line_i  = int'(CURRENT_LINE);
        in_roi  = PIXEL_VALID && (col_i >= X0) && (col_i < X0 + W)
                  && (line_i >= Y0) && (line_i < Y0 + HT);
        empty   = (count == '0);
        full    = (count == FULL_CNT);
        pop     = !empty && M_READY;
        // A pop on the same cycle frees the slot, so only an unrelieved full push is lost.
        ovf_evt = push_vld && full && !pop;
        push_ok = push_vld && !ovf_evt;
        capture = (state == ACTIVE) && FRAME_VALID && in_roi && !ovf_evt;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:   if (!FRAME_VALID) state_nxt = ARMED;
            ARMED:  if (FRAME_VALID) state_nxt = ACTIVE;
            ACTIVE: begin
                // Hold ACTIVE for one cycle if the frame's last word is still in the push stage.
                if (ovf_evt) begin
                    state_nxt = DROP;
                end else if (!FRAME_VALID && !push_vld) begin
                    state_nxt = ARMED;
                    done_nxt  = 1'b1;
                end
            end
            DROP:   if (!FRAME_VALID) state_nxt = ARMED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PIXCLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= IDLE;
            FRAME_DONE     <= 1'b0;
            OVERFLOW       <= 1'b0;
            DROPPED_FRAMES <= 8'd0;
        end else begin
            state      <= state_nxt;
            FRAME_DONE <= done_nxt;
            if (ovf_evt) begin
                OVERFLOW <= 1'b1;
                if (DROPPED_FRAMES != 8'hFF) DROPPED_FRAMES <= DROPPED_FRAMES + 8'd1;
            end
        end
    end

    always_ff @(posedge PIXCLK or negedge RST_N) begin
        if (!RST_N) begin
            col      <= '0;
            lane     <= 2'd0;
            acc      <= '0;
            sof_pend <= 1'b0;
            push_vld <= 1'b0;
            push_sof <= 1'b0;
            push_eol <= 1'b0;
            push_dat <= '0;
        end else begin
            push_vld <= 1'b0;
            col <= (PIXEL_VALID && FRAME_VALID) ? col + CW'(1) : '0;
            if (state == ARMED && FRAME_VALID) sof_pend <= 1'b1;

            if (state != ACTIVE || !PIXEL_VALID || !FRAME_VALID) begin
                lane <= 2'd0;
            end else if (capture) begin
                lane <= lane + 2'd1;
                case (lane)
                    2'd0: acc[7:0]   <= DATA_IN[9:2];
                    2'd1: acc[15:8]  <= DATA_IN[9:2];
                    2'd2: acc[23:16] <= DATA_IN[9:2];
                    default: begin
                        push_vld <= 1'b1;
                        push_dat <= {DATA_IN[9:2], acc};
                        push_sof <= sof_pend;
                        push_eol <= (col_i == X0 + W - 1);
                        sof_pend <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge PIXCLK) begin
        if (push_ok) mem[wr_ptr] <= {push_sof, push_eol, push_dat};
    end

    always_ff @(posedge PIXCLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign M_VALID = !empty;
    assign {M_SOF, M_EOL, M_DATA} = empty ? 34'd0 : mem[rd_ptr];

endmodule
